// File: rtl/secure_register_arbiter.sv
// Round-robin access arbiter guarding one protected register; only thread ID 0 may touch it.
// Requesters that accumulate MAX_VIOL denied accesses are locked out until reset.
module secure_register_arbiter #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_REQ     = 4,
   parameter int                    TID_WIDTH   = 4,
   parameter int                    MAX_VIOL    = 3,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_wr,
   input  logic [NUM_REQ*TID_WIDTH-1:0]  req_tid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          done,
   output logic                          err,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic [NUM_REQ-1:0]            locked
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_VIOL + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    wr_q, wr_d;
   logic [TID_WIDTH-1:0]    tid_q, tid_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   reg_q, reg_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic [NUM_REQ-1:0]      gnt_q, gnt_d;
   logic                    done_q, done_d;
   logic [IDX_W-1:0]        rr_q, rr_d;
   logic [CNT_W-1:0]        viol_q [NUM_REQ];
   logic [CNT_W-1:0]        viol_d [NUM_REQ];
   logic [NUM_REQ-1:0]      locked_q, locked_d;

   logic [NUM_REQ-1:0]      eligible_s;
   logic                    found_s;
   logic [IDX_W-1:0]        pick_s;

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
      return sum[IDX_W-1:0];
   endfunction

   // Round-robin pick: first eligible requester searching upward from the last winner + 1.
   always_comb begin
      eligible_s = req & ~locked_q;
      found_s    = 1'b0;
      pick_s     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pick_s  = (!found_s && eligible_s[wrap_idx(rr_q, k)]) ? wrap_idx(rr_q, k) : pick_s;
         found_s = found_s | eligible_s[wrap_idx(rr_q, k)];
      end
   end

   // Next-state and datapath updates for the IDLE -> CHECK -> RESP transaction sequence.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wr_d     = wr_q;
      tid_d    = tid_q;
      wdata_d  = wdata_q;
      reg_d    = reg_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      gnt_d    = '0;
      done_d   = 1'b0;
      rr_d     = rr_q;
      viol_d   = viol_q;
      locked_d = locked_q;

      case (state_q)
         S_IDLE: begin
            if (found_s) begin
               idx_d   = pick_s;
               wr_d    = req_wr[pick_s];
               tid_d   = req_tid[int'(pick_s)*TID_WIDTH +: TID_WIDTH];
               wdata_d = req_wdata[int'(pick_s)*DATA_WIDTH +: DATA_WIDTH];
               state_d = S_CHECK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CHECK: begin
            if (tid_q == '0) begin
               if (wr_q) begin
                  reg_d = wdata_q;
               end else begin
                  rdata_d = reg_q;
               end
               err_d = 1'b0;
            end else begin
               rdata_d = '0;
               err_d   = 1'b1;
               if (viol_q[idx_q] < CNT_W'(MAX_VIOL)) begin
                  viol_d[idx_q] = viol_q[idx_q] + 1'b1;
               end else begin
                  viol_d[idx_q] = viol_q[idx_q];
               end
               // Lock on the violation that brings the count to MAX_VIOL.
               if (viol_q[idx_q] >= CNT_W'(MAX_VIOL - 1)) begin
                  locked_d[idx_q] = 1'b1;
               end else begin
                  locked_d[idx_q] = locked_q[idx_q];
               end
            end
            gnt_d[idx_q] = 1'b1;
            done_d       = 1'b1;
            state_d      = S_RESP;
         end
         S_RESP: begin
            rr_d    = idx_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         tid_q    <= '0;
         wdata_q  <= '0;
         reg_q    <= RESET_VALUE;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         gnt_q    <= '0;
         done_q   <= 1'b0;
         rr_q     <= IDX_W'(NUM_REQ - 1);
         locked_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            viol_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wr_q     <= wr_d;
         tid_q    <= tid_d;
         wdata_q  <= wdata_d;
         reg_q    <= reg_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         rr_q     <= rr_d;
         locked_q <= locked_d;
         viol_q   <= viol_d;
      end
   end

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign err    = err_q;
   assign rdata  = rdata_q;
   assign locked = locked_q;

endmodule

// File: tb/tb_secure_register_arbiter.sv
// Self-checking bench for secure_register_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model of arbitration, access control and lockout.
module tb_secure_register_arbiter;

   localparam int DW = 32;
   localparam int NR = 4;
   localparam int TW = 4;
   localparam int MV = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req = '0;
   logic [NR-1:0]   req_wr = '0;
   logic [NR*TW-1:0] req_tid = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR-1:0]   gnt;
   logic            done;
   logic            err;
   logic [DW-1:0]   rdata;
   logic [NR-1:0]   locked;

   int n_run  = 0;
   int n_fail = 0;

   secure_register_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR),
      .TID_WIDTH  (TW),
      .MAX_VIOL   (MV),
      .RESET_VALUE('0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_wr   (req_wr),
      .req_tid  (req_tid),
      .req_wdata(req_wdata),
      .gnt      (gnt),
      .done     (done),
      .err      (err),
      .rdata    (rdata),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (transaction level) ----------------
   logic [DW-1:0] m_reg;
   logic [DW-1:0] m_rdata;
   logic          m_err;
   int            m_viol [NR];
   logic [NR-1:0] m_locked;
   int            m_last;

   task automatic model_reset();
      m_reg    = '0;
      m_rdata  = '0;
      m_err    = 1'b0;
      m_locked = '0;
      m_last   = NR - 1;
      for (int i = 0; i < NR; i++) m_viol[i] = 0;
   endtask

   function automatic int model_pick(input logic [NR-1:0] r);
      for (int k = 1; k <= NR; k++) begin
         int j;
         j = (m_last + k) % NR;
         if (r[j] && !m_locked[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_access(input int i, input logic wr, input logic [TW-1:0] tid, input logic [DW-1:0] wd);
      if (tid == '0) begin
         m_err = 1'b0;
         if (wr) m_reg = wd;
         else    m_rdata = m_reg;
      end else begin
         m_err   = 1'b1;
         m_rdata = '0;
         if (m_viol[i] < MV) m_viol[i] = m_viol[i] + 1;
         if (m_viol[i] == MV) m_locked[i] = 1'b1;
      end
      m_last = i;
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic do_reset();
      rst       = 1'b1;
      req       = '0;
      req_wr    = '0;
      req_tid   = '0;
      req_wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [TW-1:0] tid, input logic [DW-1:0] wd);
      req[i]                = 1'b1;
      req_wr[i]             = wr;
      req_tid[i*TW +: TW]   = tid;
      req_wdata[i*DW +: DW] = wd;
   endtask

   // Waits (bounded) for a done strobe, sampling on falling edges.
   task automatic wait_done(input int budget, output int cyc, output logic seen);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1'b1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_run++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      n_run++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      n_run++; if (locked !== 4'b0000) begin n_fail++; $display("FAIL reset_locked: got %b expected 0000", locked); end
      repeat (3) @(negedge clk);
      n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL idle_done: got %b expected 0", done); end
   endtask

   task automatic test_basic_read();
      set_req(0, 1'b0, 4'd0, 32'h0);
      @(negedge clk);
      n_run++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL t1_early_gnt: got %b expected 0000", gnt); end
      @(negedge clk);
      req = '0;
      n_run++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL t1_gnt: got %b expected 0001", gnt); end
      n_run++; if (done !== 1'b1) begin n_fail++; $display("FAIL t1_done: got %b expected 1", done); end
      n_run++; if (err !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL t1_resp: got err=%b rdata=%h expected err=0 rdata=0", err, rdata); end
      @(negedge clk);
      n_run++; if (done !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL t1_strobe_len: got done=%b gnt=%b expected 0/0000", done, gnt); end
   endtask

   task automatic test_write_read();
      int cyc; logic seen;
      set_req(1, 1'b1, 4'd0, 32'hDEADBEEF);
      wait_done(8, cyc, seen);
      req = '0;
      n_run++; if (!seen || gnt !== 4'b0010 || err !== 1'b0) begin n_fail++; $display("FAIL t2_write: got seen=%b gnt=%b err=%b expected 1/0010/0", seen, gnt, err); end
      n_run++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL t2_write_rdata_hold: got %h expected 0", rdata); end
      set_req(2, 1'b0, 4'd0, 32'h0);
      wait_done(8, cyc, seen);
      req = '0;
      n_run++; if (!seen || gnt !== 4'b0100) begin n_fail++; $display("FAIL t2_read_gnt: got seen=%b gnt=%b expected 1/0100", seen, gnt); end
      n_run++; if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin n_fail++; $display("FAIL t2_read_data: got rdata=%h err=%b expected deadbeef/0", rdata, err); end
   endtask

   task automatic test_violation();
      int cyc; logic seen;
      set_req(3, 1'b1, 4'd5, 32'h12345678);
      wait_done(8, cyc, seen);
      req = '0;
      n_run++; if (!seen || gnt !== 4'b1000 || err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL t3_denied: got seen=%b gnt=%b err=%b rdata=%h expected 1/1000/1/0", seen, gnt, err, rdata); end
      set_req(0, 1'b0, 4'd0, 32'h0);
      wait_done(8, cyc, seen);
      req = '0;
      n_run++; if (!seen || rdata !== 32'hDEADBEEF || err !== 1'b0) begin n_fail++; $display("FAIL t3_reg_intact: got seen=%b rdata=%h err=%b expected 1/deadbeef/0", seen, rdata, err); end
   endtask

   task automatic test_round_robin();
      int cyc; logic seen;
      int order [5] = '{0, 1, 2, 3, 0};
      logic [NR-1:0] eg;
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 4'd0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         wait_done(8, cyc, seen);
         eg = '0;
         eg[order[k]] = 1'b1;
         n_run++; if (!seen || gnt !== eg) begin n_fail++; $display("FAIL t4_rr_gnt%0d: got seen=%b gnt=%b expected %b", k, seen, gnt, eg); end
         n_run++; if (cyc !== ((k == 0) ? 2 : 3)) begin n_fail++; $display("FAIL t4_rr_spacing%0d: got %0d cycles expected %0d", k, cyc, (k == 0) ? 2 : 3); end
      end
      req = '0;
   endtask

   task automatic test_lockout();
      int cyc; logic seen;
      logic [NR-1:0] el;
      for (int k = 0; k < MV; k++) begin
         set_req(2, 1'($urandom_range(0, 1)), 4'd7, $urandom());
         wait_done(8, cyc, seen);
         req = '0;
         el = (k == MV - 1) ? 4'b0100 : 4'b0000;
         n_run++; if (!seen || gnt !== 4'b0100 || err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL t5_viol%0d: got seen=%b gnt=%b err=%b rdata=%h expected 1/0100/1/0", k, seen, gnt, err, rdata); end
         n_run++; if (locked !== el) begin n_fail++; $display("FAIL t5_locked%0d: got %b expected %b", k, locked, el); end
      end
      set_req(2, 1'b0, 4'd0, 32'h0);
      wait_done(10, cyc, seen);
      n_run++; if (seen) begin n_fail++; $display("FAIL t5_locked_ignored: got done with gnt=%b expected no done", gnt); end
      set_req(1, 1'b1, 4'd0, 32'h55AA55AA);
      wait_done(8, cyc, seen);
      req[1] = 1'b0;
      n_run++; if (!seen || gnt !== 4'b0010 || err !== 1'b0) begin n_fail++; $display("FAIL t5_other_write: got seen=%b gnt=%b err=%b expected 1/0010/0", seen, gnt, err); end
      set_req(3, 1'b0, 4'd0, 32'h0);
      wait_done(8, cyc, seen);
      req = '0;
      n_run++; if (!seen || gnt !== 4'b1000 || rdata !== 32'h55AA55AA) begin n_fail++; $display("FAIL t5_other_read: got seen=%b gnt=%b rdata=%h expected 1/1000/55aa55aa", seen, gnt, rdata); end
   endtask

   task automatic test_reset_mid();
      int cyc; logic seen;
      @(negedge clk);
      set_req(1, 1'b1, 4'd0, 32'hA5A5A5A5);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_run++; if (gnt !== 4'b0000 || done !== 1'b0) begin n_fail++; $display("FAIL t6_no_gnt: got gnt=%b done=%b expected 0000/0", gnt, done); end
      n_run++; if (locked !== 4'b0000) begin n_fail++; $display("FAIL t6_locked_clear: got %b expected 0000", locked); end
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      wait_done(5, cyc, seen);
      n_run++; if (seen) begin n_fail++; $display("FAIL t6_late_gnt: got gnt=%b expected no done", gnt); end
      set_req(2, 1'b1, 4'd9, 32'h0);
      wait_done(8, cyc, seen);
      req = '0;
      n_run++; if (!seen || err !== 1'b1 || locked !== 4'b0000) begin n_fail++; $display("FAIL t6_counter_clear: got seen=%b err=%b locked=%b expected 1/1/0000", seen, err, locked); end
      set_req(0, 1'b0, 4'd0, 32'h0);
      wait_done(8, cyc, seen);
      req = '0;
      n_run++; if (!seen || rdata !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL t6_reg_reset: got seen=%b rdata=%h err=%b expected 1/0/0", seen, rdata, err); end
   endtask

   task automatic test_random();
      int cyc; logic seen; int exp;
      logic [NR-1:0] reqv; logic [NR-1:0] eg;
      logic           r_wr  [NR];
      logic [TW-1:0]  r_tid [NR];
      logic [DW-1:0]  r_wd  [NR];
      do_reset();
      model_reset();
      for (int it = 0; it < 60; it++) begin
         reqv = NR'($urandom_range(1, 15));
         for (int i = 0; i < NR; i++) begin
            r_wr[i]  = 1'($urandom_range(0, 1));
            r_tid[i] = ($urandom_range(0, 7) == 0) ? TW'($urandom_range(1, 15)) : 4'd0;
            r_wd[i]  = $urandom();
            if (reqv[i]) set_req(i, r_wr[i], r_tid[i], r_wd[i]);
         end
         exp = model_pick(reqv);
         if (exp < 0) begin
            wait_done(6, cyc, seen);
            req = '0;
            n_run++; if (seen) begin n_fail++; $display("FAIL rnd%0d_locked_ignored: got gnt=%b expected no done", it, gnt); end
         end else begin
            wait_done(8, cyc, seen);
            req = '0;
            model_access(exp, r_wr[exp], r_tid[exp], r_wd[exp]);
            eg = '0;
            eg[exp] = 1'b1;
            n_run++; if (!seen || gnt !== eg || cyc !== 2) begin n_fail++; $display("FAIL rnd%0d_gnt: got seen=%b gnt=%b cyc=%0d expected 1/%b/2", it, seen, gnt, cyc, eg); end
            n_run++; if (err !== m_err || rdata !== m_rdata) begin n_fail++; $display("FAIL rnd%0d_resp: got err=%b rdata=%h expected err=%b rdata=%h", it, err, rdata, m_err, m_rdata); end
            n_run++; if (locked !== m_locked) begin n_fail++; $display("FAIL rnd%0d_locked: got %b expected %b", it, locked, m_locked); end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_write_read();
      test_violation();
      test_round_robin();
      test_lockout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
